// File: rtl/syncport_seq_ctrl.sv
// ============================================================================
// Module   : syncport_seq_ctrl
// Purpose  : Sequences a bank of SyncPort channels through fire / catch-or-
//            timeout / gap steps for a programmed number of rounds.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module syncport_seq_ctrl #(
    parameter int N_CH       = 4,
    parameter int _CNT_WIDTH = 32
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    input  logic                  io_start,
    input  logic                  io_abort,
    input  logic [N_CH-1:0]       io_chMask,
    input  logic [15:0]           io_repeat,
    input  logic [_CNT_WIDTH-1:0] io_fbTimeout,
    input  logic [_CNT_WIDTH-1:0] io_gapCnt,
    input  logic [N_CH-1:0]       io_fbCatch,
    output logic [N_CH-1:0]       io_pulseEn,
    output logic                  io_busy,
    output logic                  io_done,
    output logic                  io_aborted,
    output logic [N_CH-1:0]       io_errFlag,
    output logic [3:0]            io_curCh,
    output logic [15:0]           io_roundCnt,
    output logic                  work_End
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_FIRE   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0]            c_LAST_CH  = 4'(N_CH - 1);
    localparam logic [N_CH-1:0]       c_ONE_CH   = {{(N_CH-1){1'b0}}, 1'b1};
    localparam logic [_CNT_WIDTH-1:0] c_CNT_ONE  = {{(_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [_CNT_WIDTH-1:0] c_CNT_ZERO = '0;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nx;
    logic [2:0]            w_eoc_state;

    logic [N_CH-1:0]       r_mask;
    logic [15:0]           r_repeat;
    logic [_CNT_WIDTH-1:0] r_timeout;
    logic [_CNT_WIDTH-1:0] r_gapLast;
    logic [_CNT_WIDTH-1:0] r_timer;
    logic [N_CH-1:0]       r_catch_d;

    logic [N_CH-1:0]       r_pulseEn;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_aborted;
    logic [N_CH-1:0]       r_errFlag;
    logic [3:0]            r_curCh;
    logic [15:0]           r_roundCnt;

    logic [N_CH-1:0]       w_pulse_nx;
    logic                  w_aborted_nx;
    logic [N_CH-1:0]       w_err_nx;
    logic [3:0]            w_curCh_nx;
    logic [15:0]           w_round_nx;
    logic [_CNT_WIDTH-1:0] w_timer_nx;

    logic [15:0]           w_mask16;
    logic [15:0]           w_catch16;
    logic [15:0]           w_catchd16;
    logic [N_CH-1:0]       w_onehot;
    logic                  w_mask_bit;
    logic                  w_ev;
    logic                  w_tmo;
    logic                  w_gap_end;
    logic                  w_last_ch;
    logic [15:0]           w_round_inc;
    logic                  w_round_done;
    logic                  w_active;
    logic                  w_eoc_take;
    logic                  w_start_ok;

    // Zero-extended copies let a 4-bit channel index address any N_CH.
    assign w_mask16     = 16'(r_mask);
    assign w_catch16    = 16'(io_fbCatch);
    assign w_catchd16   = 16'(r_catch_d);
    assign w_onehot     = c_ONE_CH << r_curCh;
    assign w_mask_bit   = w_mask16[r_curCh];
    assign w_ev         = w_catch16[r_curCh] & ~w_catchd16[r_curCh];
    assign w_tmo        = (r_timeout != c_CNT_ZERO) && (r_timer == (r_timeout - c_CNT_ONE));
    assign w_gap_end    = (r_timer == r_gapLast);
    assign w_last_ch    = (r_curCh == c_LAST_CH);
    assign w_round_inc  = r_roundCnt + 16'd1;
    assign w_round_done = (w_round_inc == r_repeat);
    assign w_eoc_state  = (w_last_ch && w_round_done) ? S_DONE : S_SELECT;
    assign w_start_ok   = (r_state == S_IDLE) && io_start;
    assign w_active     = (r_state == S_SELECT) || (r_state == S_FIRE) ||
                          (r_state == S_WAIT)   || (r_state == S_GAP);
    assign w_eoc_take   = !io_abort &&
                          (((r_state == S_SELECT) && !w_mask_bit) ||
                           ((r_state == S_GAP) && w_gap_end));

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_start) begin
                    w_state_nx = ((io_chMask == '0) || (io_repeat == 16'd0)) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (io_abort)        w_state_nx = S_DONE;
                else if (w_mask_bit) w_state_nx = S_FIRE;
                else                 w_state_nx = w_eoc_state;
            end
            S_FIRE: begin
                w_state_nx = io_abort ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (io_abort)           w_state_nx = S_DONE;
                else if (w_ev || w_tmo) w_state_nx = S_GAP;
            end
            S_GAP: begin
                if (io_abort)       w_state_nx = S_DONE;
                else if (w_gap_end) w_state_nx = w_eoc_state;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_curCh_nx   = r_curCh;
        w_round_nx   = r_roundCnt;
        w_err_nx     = r_errFlag;
        w_aborted_nx = r_aborted;
        w_timer_nx   = r_timer;
        case (r_state)
            S_IDLE: begin
                if (io_start) begin
                    w_curCh_nx   = 4'd0;
                    w_round_nx   = 16'd0;
                    w_err_nx     = '0;
                    w_aborted_nx = 1'b0;
                end
            end
            S_FIRE: w_timer_nx = c_CNT_ZERO;
            S_WAIT: begin
                w_timer_nx = r_timer + c_CNT_ONE;
                if (!io_abort && w_ev) begin
                    w_timer_nx = c_CNT_ZERO;
                end else if (!io_abort && w_tmo) begin
                    // A catch in the expiry cycle takes priority, so the flag is set only here.
                    w_timer_nx = c_CNT_ZERO;
                    w_err_nx   = r_errFlag | w_onehot;
                end
            end
            S_GAP:   w_timer_nx = r_timer + c_CNT_ONE;
            default: w_timer_nx = r_timer;
        endcase
        if (w_active && io_abort) begin
            w_aborted_nx = 1'b1;
        end
        if (w_eoc_take) begin
            if (!w_last_ch) begin
                w_curCh_nx = r_curCh + 4'd1;
            end else begin
                w_round_nx = w_round_inc;
                if (!w_round_done) begin
                    w_curCh_nx = 4'd0;
                end
            end
        end
        w_pulse_nx = (w_state_nx == S_FIRE) ? w_onehot : '0;
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            r_mask     <= '0;
            r_repeat   <= '0;
            r_timeout  <= '0;
            r_gapLast  <= '0;
            r_timer    <= '0;
            r_catch_d  <= '0;
            r_pulseEn  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_errFlag  <= '0;
            r_curCh    <= '0;
            r_roundCnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_mask    <= io_chMask;
                r_repeat  <= io_repeat;
                r_timeout <= io_fbTimeout;
                // A gap of 0 still costs one cycle, so store the last count value.
                r_gapLast <= (io_gapCnt == c_CNT_ZERO) ? c_CNT_ZERO : (io_gapCnt - c_CNT_ONE);
            end
            r_timer    <= w_timer_nx;
            r_catch_d  <= io_fbCatch;
            r_pulseEn  <= w_pulse_nx;
            r_busy     <= (w_state_nx != S_IDLE);
            r_done     <= (w_state_nx == S_DONE);
            r_aborted  <= w_aborted_nx;
            r_errFlag  <= w_err_nx;
            r_curCh    <= w_curCh_nx;
            r_roundCnt <= w_round_nx;
        end
    end

    // Abort must kill a strobe in the very FIRE cycle it is raised in, hence the gate.
    assign io_pulseEn  = r_pulseEn & {N_CH{~io_abort}};
    assign io_busy     = r_busy;
    assign io_done     = r_done;
    assign work_End    = r_done;
    assign io_aborted  = r_aborted;
    assign io_errFlag  = r_errFlag;
    assign io_curCh    = r_curCh;
    assign io_roundCnt = r_roundCnt;

endmodule

`default_nettype wire

// File: tb/tb_syncport_seq_ctrl.sv
// ============================================================================
// Module   : tb_syncport_seq_ctrl
// Purpose  : Directed self-checking bench for syncport_seq_ctrl (N_CH = 4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_syncport_seq_ctrl;

    logic        io_clk = 1'b0;
    logic        io_rst_n;
    logic        io_start;
    logic        io_abort;
    logic [3:0]  io_chMask;
    logic [15:0] io_repeat;
    logic [31:0] io_fbTimeout;
    logic [31:0] io_gapCnt;
    logic [3:0]  io_fbCatch;
    logic [3:0]  io_pulseEn;
    logic        io_busy;
    logic        io_done;
    logic        io_aborted;
    logic [3:0]  io_errFlag;
    logic [3:0]  io_curCh;
    logic [15:0] io_roundCnt;
    logic        work_End;

    int total = 0;
    int bad   = 0;

    int n_pulse, done_cnt, done_cyc, err_cyc, we_bad, multi_bad, finished;
    int plog [0:31];
    int pcyc [0:31];

    syncport_seq_ctrl #(.N_CH(4), ._CNT_WIDTH(32)) dut (
        .io_clk      (io_clk),
        .io_rst_n    (io_rst_n),
        .io_start    (io_start),
        .io_abort    (io_abort),
        .io_chMask   (io_chMask),
        .io_repeat   (io_repeat),
        .io_fbTimeout(io_fbTimeout),
        .io_gapCnt   (io_gapCnt),
        .io_fbCatch  (io_fbCatch),
        .io_pulseEn  (io_pulseEn),
        .io_busy     (io_busy),
        .io_done     (io_done),
        .io_aborted  (io_aborted),
        .io_errFlag  (io_errFlag),
        .io_curCh    (io_curCh),
        .io_roundCnt (io_roundCnt),
        .work_End    (work_End)
    );

    always #5 io_clk = ~io_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge io_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Starts a run, returns catches cdly cycles after each strobe (cdly < 0: none)
    // and optionally pulses a start with different settings at cycle bstart.
    task automatic run_seq(input logic [3:0] m, input logic [15:0] r, input logic [31:0] t,
                           input logic [31:0] g, input int cdly, input int maxc, input int bstart);
        int cyc, catch_at, catch_clr, catch_ch;
        io_chMask = m; io_repeat = r; io_fbTimeout = t; io_gapCnt = g;
        io_start = 1'b1;
        n_pulse = 0; done_cnt = 0; done_cyc = -1; err_cyc = -1; we_bad = 0; multi_bad = 0;
        finished = 0; cyc = 0; catch_at = -1; catch_clr = -1; catch_ch = 0;
        for (int i = 0; i < 32; i++) begin plog[i] = -1; pcyc[i] = -1000; end
        while (finished == 0 && cyc < maxc) begin
            step();
            cyc++;
            if (cyc == 1) io_start = 1'b0;
            if (cyc == catch_clr) io_fbCatch = 4'b0000;
            if (io_pulseEn != 4'b0000) begin
                if (!$onehot(io_pulseEn)) multi_bad++;
                if (n_pulse < 32) begin
                    plog[n_pulse] = idx_of(io_pulseEn);
                    pcyc[n_pulse] = cyc;
                end
                n_pulse++;
                if (cdly >= 0) begin catch_at = cyc + cdly; catch_ch = idx_of(io_pulseEn); end
            end
            if (cyc == catch_at) begin io_fbCatch[catch_ch] = 1'b1; catch_clr = cyc + 2; end
            if (err_cyc < 0 && io_errFlag != 4'b0000) err_cyc = cyc;
            if (io_done) begin done_cnt++; done_cyc = cyc; end
            if (io_done !== work_End) we_bad++;
            if (cyc == bstart) begin io_start = 1'b1; io_chMask = 4'b0001; io_repeat = 16'd1; end
            if (cyc == bstart + 1) io_start = 1'b0;
            if (done_cyc > 0 && cyc == done_cyc + 1) finished = 1;
        end
        io_start = 1'b0;
        io_fbCatch = 4'b0000;
        check("run_finished", finished, 1);
        check("busy_after_done", io_busy, 1'b0);
        check("done_once", done_cnt, 1);
        check("workEnd_with_done", we_bad, 0);
        check("pulse_onehot", multi_bad, 0);
    endtask

    initial begin
        int npl, saw_done;
        io_rst_n = 1'b0; io_start = 1'b0; io_abort = 1'b0; io_chMask = '0; io_repeat = '0;
        io_fbTimeout = '0; io_gapCnt = '0; io_fbCatch = '0;
        repeat (3) step();
        check("rst_pulseEn", io_pulseEn, 4'b0000);
        check("rst_busy", io_busy, 1'b0);
        check("rst_done", io_done, 1'b0);
        check("rst_workEnd", work_End, 1'b0);
        check("rst_aborted", io_aborted, 1'b0);
        check("rst_errFlag", io_errFlag, 4'b0000);
        check("rst_curCh", io_curCh, 4'd0);
        check("rst_roundCnt", io_roundCnt, 16'd0);
        io_rst_n = 1'b1;
        step();

        // Mask 0101, one round, catch 5 cycles after each strobe, gap 3.
        run_seq(4'b0101, 16'd1, 32'd0, 32'd3, 5, 200, -1);
        check("A_npulse", n_pulse, 2);
        check("A_first_ch", plog[0], 0);
        check("A_second_ch", plog[1], 2);
        check("A_fire_latency", pcyc[0], 2);
        check("A_pulse_spacing", pcyc[1] - pcyc[0], 11);
        check("A_done_latency", done_cyc - pcyc[1], 10);
        check("A_roundCnt", io_roundCnt, 16'd1);
        check("A_errFlag", io_errFlag, 4'b0000);
        check("A_curCh_hold", io_curCh, 4'd3);

        // Timeout of 300 on channel 1 with no catch.
        run_seq(4'b0010, 16'd1, 32'd300, 32'd0, -1, 1000, -1);
        check("B_npulse", n_pulse, 1);
        check("B_ch", plog[0], 1);
        check("B_wait_len", err_cyc - pcyc[0], 301);
        check("B_done_latency", done_cyc - pcyc[0], 304);
        check("B_errFlag", io_errFlag, 4'b0010);
        check("B_roundCnt", io_roundCnt, 16'd1);
        check("B_aborted", io_aborted, 1'b0);

        // Catch edge lands in the expiry cycle: catch wins.
        run_seq(4'b0001, 16'd1, 32'd10, 32'd0, 10, 200, -1);
        check("C1_errFlag", io_errFlag, 4'b0000);
        check("C1_no_err_seen", err_cyc, -1);
        check("C1_done_latency", done_cyc - pcyc[0], 15);
        // One cycle later the timeout has already fired.
        run_seq(4'b0001, 16'd1, 32'd10, 32'd0, 11, 200, -1);
        check("C2_errFlag", io_errFlag, 4'b0001);
        check("C2_err_time", err_cyc - pcyc[0], 11);

        // Three rounds over all channels; a start pulse mid-run must be ignored.
        run_seq(4'b1111, 16'd3, 32'd0, 32'd2, 3, 400, 10);
        check("D_npulse", n_pulse, 12);
        for (int i = 0; i < 12; i++) check($sformatf("D_order_%0d", i), plog[i], i % 4);
        check("D_span", pcyc[11] - pcyc[0], 77);
        check("D_done_latency", done_cyc - pcyc[11], 6);
        check("D_roundCnt", io_roundCnt, 16'd3);
        check("D_errFlag", io_errFlag, 4'b0000);

        // Abort raised in the second-round FIRE cycle.
        io_chMask = 4'b0001; io_repeat = 16'd2; io_fbTimeout = 32'd0; io_gapCnt = 32'd1;
        io_start = 1'b1;
        step();
        io_start = 1'b0;
        check("E_busy_rise", io_busy, 1'b1);
        check("E_select_nopulse", io_pulseEn, 4'b0000);
        step();
        check("E_fire1", io_pulseEn, 4'b0001);
        step(); step();
        io_fbCatch = 4'b0001;
        step();
        io_fbCatch = 4'b0000;
        repeat (4) step();
        check("E_round1", io_roundCnt, 16'd1);
        check("E_pre_fire", io_pulseEn, 4'b0000);
        step();
        check("E_fire2", io_pulseEn, 4'b0001);
        io_abort = 1'b1;
        #1;
        check("E_fire_suppressed", io_pulseEn, 4'b0000);
        step();
        io_abort = 1'b0;
        check("E_done", io_done, 1'b1);
        check("E_workEnd", work_End, 1'b1);
        check("E_aborted", io_aborted, 1'b1);
        check("E_roundCnt_kept", io_roundCnt, 16'd1);
        check("E_no_pulse_done", io_pulseEn, 4'b0000);
        step();
        check("E_idle_busy", io_busy, 1'b0);
        check("E_idle_done", io_done, 1'b0);
        check("E_aborted_sticky", io_aborted, 1'b1);

        // Empty mask finishes at once; start held through DONE is ignored there.
        io_chMask = 4'b0000; io_repeat = 16'd5; io_start = 1'b1;
        step();
        check("F_done", io_done, 1'b1);
        check("F_busy_done", io_busy, 1'b1);
        check("F_aborted_cleared", io_aborted, 1'b0);
        check("F_nopulse", io_pulseEn, 4'b0000);
        step();
        check("F_idle_after", io_busy, 1'b0);
        check("F_nodone_after", io_done, 1'b0);
        io_chMask = 4'b1111; io_repeat = 16'd0;
        step();
        io_start = 1'b0;
        check("F_rep0_done", io_done, 1'b1);
        check("F_rep0_nopulse", io_pulseEn, 4'b0000);
        step();
        check("F_rep0_idle", io_busy, 1'b0);

        // Asynchronous reset while waiting on channel 2 in round two.
        io_chMask = 4'b0101; io_repeat = 16'd2; io_fbTimeout = 32'd5; io_gapCnt = 32'd0;
        io_start = 1'b1;
        step();
        io_start = 1'b0;
        npl = 0;
        for (int c = 0; c < 300 && npl < 4; c++) begin
            step();
            if (io_pulseEn != 4'b0000) npl++;
        end
        check("G_pulses", npl, 4);
        step(); step();
        check("G_pre_busy", io_busy, 1'b1);
        check("G_pre_curCh", io_curCh, 4'd2);
        check("G_pre_errFlag", io_errFlag, 4'b0101);
        check("G_pre_roundCnt", io_roundCnt, 16'd1);
        #2;
        io_rst_n = 1'b0;
        #1;
        check("G_busy", io_busy, 1'b0);
        check("G_curCh", io_curCh, 4'd0);
        check("G_errFlag", io_errFlag, 4'b0000);
        check("G_roundCnt", io_roundCnt, 16'd0);
        check("G_pulseEn", io_pulseEn, 4'b0000);
        saw_done = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (io_done || work_End) saw_done = 1;
        end
        io_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (io_done || work_End) saw_done = 1;
        end
        check("G_no_done", saw_done, 0);
        check("G_idle_after", io_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syncport_seq_ctrl.md
# syncport_seq_ctrl

Channel sequencer that drives a bank of `N_CH` SyncPort instances through a programmed test run. For each enabled channel in ascending index order, it:
- fires that channel's `io_pulseEn`,
- waits for the channel's `io_fbCatch` edge or a timeout,
- inserts a gap cycle count.

It repeats the sweep for `io_repeat` rounds and then pulses `work_End` so the SyncPort timing statistics close out. It sits between the host register file and the SyncPort array.

## Interface
- `N_CH`, 4, number of SyncPort channels sequenced (2..16)
- `_CNT_WIDTH`, 32, width of timeout, gap and internal cycle counters
- `io_clk`  in  1  system clock (10 MHz nominal)
- `io_rst_n`  in  1  reset, asynchronous assert, active-low
- `io_start`  in  1  start request; sampled only in IDLE
- `io_abort`  in  1  abort request; sampled in every non-IDLE state
- `io_chMask`  in  N_CH  enabled channels; latched at start
- `io_repeat`  in  16  rounds to run; latched at start
- `io_fbTimeout`  in  _CNT_WIDTH  max WAIT_FB cycles; 0 = wait forever; latched at start
- `io_gapCnt`  in  _CNT_WIDTH  idle cycles after each channel; latched at start
- `io_fbCatch`  in  N_CH  per-channel catch from SyncPort (level)
- `io_pulseEn`  out  N_CH  one-hot, one-cycle fire strobe to SyncPort
- `io_busy`  out  1  high in any state except IDLE
- `io_done`  out  1  one-cycle strobe on run completion (normal or abort)
- `io_aborted`  out  1  run ended by abort; cleared at next start
- `io_errFlag`  out  N_CH  sticky timeout flags; cleared at next start
- `io_curCh`  out  4  channel index currently addressed
- `io_roundCnt`  out  16  completed rounds in current/last run
- `work_End`  out  1  one-cycle strobe, coincident with `io_done`

## Operation
- Reset values: FSM = IDLE. All outputs are 0, including `io_pulseEn`, `io_busy`, `io_done`, `io_aborted`, `io_errFlag`, `io_curCh`, `io_roundCnt` and `work_End`.
- All outputs are registered. `catch_d` is a one-register copy of `io_fbCatch`.
- `ev = io_fbCatch[curCh] & ~catch_d[curCh]` (rising edge). A level already high at FIRE does not count.
- **IDLE**, on `io_start = 1`:
  - Latch mask, repeat, timeout and gap.
  - Clear `errFlag`, `aborted` and `roundCnt`; set `curCh = 0`.
  - If mask == 0 or repeat == 0, go to DONE; otherwise go to SELECT.
- **SELECT**, examines one channel per cycle:
  - If `mask[curCh]`, go to FIRE.
  - Otherwise advance with the end-of-channel rule below.
- **FIRE**: `io_pulseEn[curCh] = 1` for exactly this cycle. Clear the timer, then go to WAIT_FB.
- **WAIT_FB**: the timer increments each cycle.
  - If `ev`, go to GAP.
  - Else if timeout ≠ 0 and timer == timeout − 1, set `errFlag[curCh]` and go to GAP.
  - If `ev` and timeout expiry fall in the same cycle, catch wins and the flag is not set.
- **GAP**: stay for `max(gapCnt, 1)` cycles, then apply the end-of-channel rule.
- **End-of-channel rule**:
  - If `curCh < N_CH − 1`: `curCh++`, go to SELECT.
  - Otherwise: `roundCnt++`. If the new `roundCnt == repeat`, go to DONE; else `curCh = 0`, go to SELECT.
- **DONE**: `io_done = 1` and `work_End = 1` for one cycle, then go to IDLE. `curCh` and `roundCnt` hold their values.
- **Abort**: `io_abort = 1` in SELECT, FIRE, WAIT_FB or GAP causes:
  - next state DONE, with `aborted` set;
  - `io_pulseEn` forced to 0 that cycle, so an abort in FIRE suppresses the fire;
  - `errFlag` and `roundCnt` keep their values.
- `io_start` while busy is ignored. `io_start` in the DONE cycle is ignored.
- `roundCnt` does not wrap: the maximum repeat is 65535 and the compare is exact.
- Input changes to mask, repeat, timeout or gap during a run have no effect.
- Reset mid-run: all state returns to reset values immediately (asynchronous), and no `done` strobe is generated.

## Timing
- Start sampled at edge k with `mask[0] = 1`: SELECT at k+1, FIRE (`pulseEn[0]` high) at k+2, WAIT_FB from k+3.
- `ev` latency: an `io_fbCatch` rising at edge j is seen in WAIT_FB at edge j+1; GAP begins at j+2.
- A timeout of T means WAIT_FB lasts T cycles.
- Each disabled channel costs one SELECT cycle.
- Per enabled channel, the minimum cycle count is: 1 SELECT + 1 FIRE + WAIT_FB + `max(gap, 1)`.
- `io_busy` rises at k+1 and falls the cycle after DONE. DONE is the last busy cycle.

## Test plan
- Reset, with `N_CH = 4`, mask = 4'b0101, repeat = 1, timeout = 0, gap = 3, and catch returned 5 cycles after each pulse -> `pulseEn` = 0001 then 0100 exactly once each; `roundCnt` = 1; `errFlag` = 0; `done` and `work_End` one cycle together.
- mask = 4'b0010, timeout = 300, no catch -> `errFlag` = 4'b0010; WAIT_FB lasts 300 cycles; run completes normally.
- Catch asserted in the same cycle the timeout expires -> no error flag.
- repeat = 3, mask = 4'b1111 -> 12 fire strobes in order 0,1,2,3 ×3; `roundCnt` = 3.
- Abort asserted in a FIRE cycle -> no `pulseEn` that cycle; DONE next; `aborted` = 1; `roundCnt` unchanged.
- Start with mask = 0 -> DONE 1 cycle after start; zero strobes. Start pulsed while busy -> ignored.
- Deassert `io_rst_n` during WAIT_FB -> all outputs 0 asynchronously; no `done` strobe.
